// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vid_pkg
//  Brief    : Shared widths, register map and reset constants for the
//             horizontal timing controller.
//  Revision : 1.0  initial release
// ============================================================================
package vid_pkg;

  localparam int VID_W = 12;

  localparam logic [2:0] VREG_PERIOD   = 3'd0;
  localparam logic [2:0] VREG_HS_START = 3'd1;
  localparam logic [2:0] VREG_HS_END   = 3'd2;
  localparam logic [2:0] VREG_HB_START = 3'd3;
  localparam logic [2:0] VREG_HB_END   = 3'd4;
  localparam logic [2:0] VREG_HALF     = 3'd5;

  localparam logic [VID_W-1:0] VID_PERIOD_RST = 12'd844;

endpackage
`default_nettype wire

// File: rtl/vid_hcount_ctl_match12.sv
`default_nettype none
// ============================================================================
//  Module   : match12
//  Brief    : 12-bit all-ones equality decode, two 6-input NAND terms + NOR.
//  Revision : 1.0  initial release
// ============================================================================
module match12
  import vid_pkg::*;
(
  input  logic [VID_W-1:0] value,
  input  logic [VID_W-1:0] target,
  output logic             eq
);

  logic [VID_W-1:0] w_same;
  logic             w_nand_lo;
  logic             w_nand_hi;

  assign w_same    = ~(value ^ target);
  assign w_nand_lo = ~(&w_same[5:0]);
  assign w_nand_hi = ~(&w_same[11:6]);
  assign eq        = ~(w_nand_lo | w_nand_hi);

endmodule
`default_nettype wire

// File: rtl/vid_hcount_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : vid_hcount_ctl
//  Brief    : Programmable horizontal counter with line_end/hsync/hblank and
//             shadowed timing registers applied at line wrap.
//             Optional macro VID_HALFLINE_EN adds half register and half_line.
//  Revision : 1.0  initial release
// ============================================================================
module vid_hcount_ctl
  import vid_pkg::*;
#(
  parameter int             W          = VID_W,
  parameter logic [W-1:0]   PERIOD_RST = VID_PERIOD_RST
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         wr,
  input  logic [2:0]   waddr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] hcount,
  output logic         line_end,
  output logic         hsync,
`ifdef VID_HALFLINE_EN
  output logic         half_line,
`endif
  output logic         hblank
);

`ifdef VID_HALFLINE_EN
  localparam int c_nreg = 6;
`else
  localparam int c_nreg = 5;
`endif
  localparam logic [2:0]   c_last_addr = 3'(c_nreg - 1);
  localparam logic [W-1:0] c_one       = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0]      r_hcount;
  logic              r_line_end;
  logic              r_hsync;
  logic              r_hblank;
  logic [W-1:0]      r_shadow [c_nreg];
  logic [W-1:0]      r_active [c_nreg];
  logic [c_nreg-1:0] w_eq;

  for (genvar i = 0; i < c_nreg; i++) begin : g_match
    match12 u_match (
      .value  (r_hcount),
      .target (r_active[i]),
      .eq     (w_eq[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount   <= '0;
      r_line_end <= 1'b0;
      r_hsync    <= 1'b0;
      r_hblank   <= 1'b0;
      for (int i = 0; i < c_nreg; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_shadow[VREG_PERIOD] <= PERIOD_RST;
      r_active[VREG_PERIOD] <= PERIOD_RST;
    end else begin
      if (wr && (waddr <= c_last_addr)) begin
        r_shadow[waddr] <= wdata;
      end
      r_line_end <= en & w_eq[VREG_PERIOD];
      if (en) begin
        r_hcount <= w_eq[VREG_PERIOD] ? '0 : r_hcount + c_one;
        // End match wins so equal start/end never produces a pulse.
        if (w_eq[VREG_HS_END]) begin
          r_hsync <= 1'b0;
        end else if (w_eq[VREG_HS_START]) begin
          r_hsync <= 1'b1;
        end
        if (w_eq[VREG_HB_END]) begin
          r_hblank <= 1'b0;
        end else if (w_eq[VREG_HB_START]) begin
          r_hblank <= 1'b1;
        end
        // Active takes the pre-write shadow; a same-cycle write lands next wrap.
        if (w_eq[VREG_PERIOD]) begin
          r_active <= r_shadow;
        end
      end
    end
  end

`ifdef VID_HALFLINE_EN
  logic r_half_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_half_line <= 1'b0;
    end else begin
      r_half_line <= en & w_eq[VREG_HALF];
    end
  end

  assign half_line = r_half_line;
`endif

  assign hcount   = r_hcount;
  assign line_end = r_line_end;
  assign hsync    = r_hsync;
  assign hblank   = r_hblank;

endmodule
`default_nettype wire

// File: tb/tb_vid_hcount_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_hcount_ctl
//  Brief    : Self-checking bench: directed scenarios plus random traffic
//             compared against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vid_hcount_ctl;

`ifdef VID_HALFLINE_EN
  localparam int NR = 6;
`else
  localparam int NR = 5;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic        wr;
  logic [2:0]  waddr;
  logic [11:0] wdata;
  logic [11:0] hcount;
  logic        line_end;
  logic        hsync;
  logic        hblank;
`ifdef VID_HALFLINE_EN
  logic        half_line;
`endif

  vid_hcount_ctl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .hcount    (hcount),
    .line_end  (line_end),
    .hsync     (hsync),
`ifdef VID_HALFLINE_EN
    .half_line (half_line),
`endif
    .hblank    (hblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_failures = 0;

  // reference model state
  int m_cnt, m_le, m_hs, m_hb, m_half;
  int m_sh[NR];
  int m_act[NR];

  // observation helpers for directed scenarios
  int cyc = 0, last_le = 0, le_interval = 0, hs_cnt = 0, hb_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic s_rst, input logic s_en, input logic s_wr,
                      input logic [2:0] s_addr, input logic [11:0] s_data);
    int nsh[NR];
    bit wrap;
    reset = s_rst; en = s_en; wr = s_wr; waddr = s_addr; wdata = s_data;
    @(posedge clk);
    nsh = m_sh;
    if (s_rst) begin
      m_cnt = 0; m_le = 0; m_hs = 0; m_hb = 0; m_half = 0;
      for (int i = 0; i < NR; i++) begin
        m_sh[i] = (i == 0) ? 844 : 0;
        m_act[i] = m_sh[i];
      end
    end else begin
      if (s_wr && int'(s_addr) < NR) nsh[s_addr] = int'(s_data);
      if (s_en) begin
        wrap = (m_cnt == m_act[0]);
        if (m_cnt == m_act[2]) m_hs = 0;
        else if (m_cnt == m_act[1]) m_hs = 1;
        if (m_cnt == m_act[4]) m_hb = 0;
        else if (m_cnt == m_act[3]) m_hb = 1;
        m_half = (NR > 5 && m_cnt == m_act[NR-1]) ? 1 : 0;
        m_le = wrap ? 1 : 0;
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap) m_act = m_sh;
      end else begin
        m_le = 0;
        m_half = 0;
      end
      m_sh = nsh;
    end
    #1;
    cyc++;
    check("hcount", int'(hcount), m_cnt);
    check("line_end", int'(line_end), m_le);
    check("hsync", int'(hsync), m_hs);
    check("hblank", int'(hblank), m_hb);
`ifdef VID_HALFLINE_EN
    check("half_line", int'(half_line), m_half);
`endif
    if (line_end === 1'b1) begin
      le_interval = cyc - last_le;
      last_le = cyc;
    end
    if (hsync === 1'b1) hs_cnt++;
    if (hblank === 1'b1) hb_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 12'd0);
  endtask

  task automatic run_until(input int v, input int maxc);
    int n = 0;
    while (int'(hcount) != v && n < maxc) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 12'd0);
      n++;
    end
    check("reach_hcount", int'(hcount), v);
  endtask

  task automatic wreg(input logic [2:0] a, input int d);
    step(1'b0, 1'b1, 1'b1, a, 12'(d));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wr = 1'b0; waddr = '0; wdata = '0;
    step(1'b1, 1'b0, 1'b0, 3'd0, 12'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 12'd0);
    check("rst_hcount", int'(hcount), 0);
    check("rst_line_end", int'(line_end), 0);

    // free-running default line: 845 cycles per line, no sync
    hs_cnt = 0; hb_cnt = 0;
    run(845 * 2 + 5);
    check("le_interval_845", le_interval, 845);
    check("hsync_idle", hs_cnt, 0);
    check("hblank_idle", hb_cnt, 0);

    // mid-line write, effective on the following line only
    run_until(100, 1000);
    wreg(3'd1, 10);
    wreg(3'd2, 20);
    run_until(0, 1000);
    hs_cnt = 0;
    run(845);
    check("hsync_width", hs_cnt, 10);

    // period write in the exact wrap cycle
    run_until(844, 1000);
    wreg(3'd0, 3);
    check("wrap_to_zero", int'(hcount), 0);
    run_until(844, 900);
    run(20);
    check("le_interval_4", le_interval, 4);

    // enable gap while hsync is high
    wreg(3'd0, 844);
    run(10);
    run_until(15, 1000);
    check("hsync_at15", int'(hsync), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'd0, 12'd0);
      check("hold_hcount", int'(hcount), 15);
      check("hold_hsync", int'(hsync), 1);
      check("hold_le", int'(line_end), 0);
    end
    step(1'b0, 1'b1, 1'b0, 3'd0, 12'd0);
    check("resume_16", int'(hcount), 16);

    // blank: equal start/end never asserts; end beyond period never clears
    wreg(3'd3, 5);
    wreg(3'd4, 5);
    run_until(0, 1000);
    hb_cnt = 0;
    run(845);
    check("hblank_equal", hb_cnt, 0);
    wreg(3'd4, 900);
    run_until(0, 1000);
    run(860);
    check("hblank_stuck", int'(hblank), 1);

    // reset mid-line with a simultaneous write that must be dropped
    run_until(400, 1000);
    step(1'b1, 1'b1, 1'b1, 3'd1, 12'd7);
    check("rst_mid_hcount", int'(hcount), 0);
    check("rst_mid_hblank", int'(hblank), 0);
    check("rst_mid_hsync", int'(hsync), 0);
    hs_cnt = 0; hb_cnt = 0;
    run(1700);
    check("post_rst_interval", le_interval, 845);
    check("post_rst_hsync", hs_cnt, 0);
    check("post_rst_hblank", hb_cnt, 0);

    // random traffic with short periods
    wreg(3'd0, 20);
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_en, r_wr;
      r_rst = ($urandom_range(0, 499) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_wr  = ($urandom_range(0, 7) == 0);
      step(r_rst, r_en, r_wr, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 45)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
`default_nettype wire
